// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Transmit half of the on-board UART. Takes one byte per start strobe from
//   the CPU-side I/O register and shifts it out as an 8N1 frame (start bit low,
//   8 data bits LSB first, stop bit high) on the TX pin.
//
// Parameters
//   CLOCK_SPEED          system clock frequency in Hz
//   BAUD_RATE            serial bit rate in bits/s
//
// Ports
//   clk                  system clock, rising edge
//   reset                synchronous, active-high reset
//   tx_strobe_start      request to send tx_parallel_data_in (honoured in IDLE only)
//   tx_parallel_data_in  byte to send, captured on the accepting edge
//   tx_serial_data_out   registered serial line, idles high
//   tx_busy              high while a frame is in flight
//   tx_done              one-cycle pulse on frame completion
module uart_transmitter #(
   parameter int CLOCK_SPEED = 20_000_000,
   parameter int BAUD_RATE   = 115_200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_strobe_start,
   input  logic [7:0] tx_parallel_data_in,
   output logic       tx_serial_data_out,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
   // Guarded so an illegal configuration still elaborates far enough to report.
   localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_cfg_check
         $error("uart_transmitter: CLOCK_SPEED / BAUD_RATE must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] baud_cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic             line_q;
   logic             busy_q;
   logic             done_q;

   logic [2:0]       bit_idx_nxt;
   logic             bit_last;

   assign bit_idx_nxt = bit_idx_q + 3'd1;
   assign bit_last    = (baud_cnt_q == CNT_LAST);

   // Outputs are driven straight from registers, so the line value for the
   // next bit is computed one edge ahead of the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         line_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               line_q <= 1'b1;
               busy_q <= 1'b0;
               if (tx_strobe_start) begin
                  // Start bit goes out on the very edge that accepts the byte.
                  shift_q    <= tx_parallel_data_in;
                  baud_cnt_q <= '0;
                  bit_idx_q  <= '0;
                  line_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_START;
               end
            end

            S_START: begin
               if (bit_last) begin
                  baud_cnt_q <= '0;
                  bit_idx_q  <= '0;
                  line_q     <= shift_q[0];
                  state_q    <= S_DATA;
               end else begin
                  baud_cnt_q <= baud_cnt_q + CNT_W'(1);
               end
            end

            S_DATA: begin
               if (bit_last) begin
                  baud_cnt_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     // Leave before the 3-bit index could wrap to bit 0.
                     line_q  <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_nxt;
                     line_q    <= shift_q[bit_idx_nxt];
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + CNT_W'(1);
               end
            end

            S_STOP: begin
               if (bit_last) begin
                  baud_cnt_q <= '0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= S_IDLE;
               end else begin
                  baud_cnt_q <= baud_cnt_q + CNT_W'(1);
               end
            end

            default: begin
               state_q <= S_IDLE;
               line_q  <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_serial_data_out = line_q;
   assign tx_busy            = busy_q;
   assign tx_done            = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
//   Bench for uart_transmitter at 10 clocks per bit. Stimulus pushes each
//   accepted byte into a queue; a monitor decodes the serial line mid-bit,
//   pops and compares whole frames, and checks busy length and done width
//   whenever tx_done is presented.
module tb_uart_transmitter;

   localparam int CPB   = 10;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic       strobe;
   logic [7:0] data;
   logic       line;
   logic       busy;
   logic       done;

   uart_transmitter #(
      .CLOCK_SPEED(2_000_000),
      .BAUD_RATE  (200_000)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .tx_strobe_start     (strobe),
      .tx_parallel_data_in (data),
      .tx_serial_data_out  (line),
      .tx_busy             (busy),
      .tx_done             (done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_q[$];
   int          done_count = 0;
   int          frames = 0;
   int unsigned last_done_cyc = 0;
   int unsigned prev_done_cyc = 0;
   int unsigned last_start_cyc = 0;

   // monitor state
   bit          mon_active = 1'b0;
   int          mon_cnt = 0;
   logic [9:0]  mon_bits = '0;
   logic [7:0]  mon_exp;
   bit          mon_prev_done = 1'b0;
   int          mon_busy_len = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: runs on the falling edge, away from DUT updates.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_active) begin
            if (busy !== 1'b1 && mon_cnt < 9 * CPB + CPB / 2 - 1) begin
               mon_active = 1'b0;   // frame cut short by reset
            end else begin
               if (mon_cnt % CPB == CPB / 2 - 1)
                  mon_bits[mon_cnt / CPB] = line;
               if (mon_cnt == 9 * CPB + CPB / 2 - 1) begin
                  mon_active = 1'b0;
                  frames++;
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_frame: got bits %b, required no frame", mon_bits);
                  end else begin
                     mon_exp = exp_q.pop_front();
                     $display("frame %0d: line bits %b, data %02h, expected %02h",
                              frames, mon_bits, mon_bits[8:1], mon_exp);
                     check("frame_bits", 32'(mon_bits), 32'({1'b1, mon_exp, 1'b0}));
                  end
               end
               mon_cnt++;
            end
         end else if (line === 1'b0) begin
            mon_active     = 1'b1;
            mon_cnt        = 1;
            last_start_cyc = cyc;
         end

         if (done === 1'b1) begin
            check("busy_length", 32'(mon_busy_len), 32'(FRAME));
            check("done_width", 32'(mon_prev_done), 32'd0);
            done_count++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
         end
         mon_prev_done = (done === 1'b1);
         if (busy === 1'b1) mon_busy_len++;
         else               mon_busy_len = 0;
      end
   end

   task automatic send(input logic [7:0] b, output int unsigned e);
      strobe = 1'b1;
      data   = b;
      tick(1);
      strobe = 1'b0;
      e      = cyc;
      exp_q.push_back(b);
      check("accept_busy", 32'(busy), 32'd1);
      check("accept_line", 32'(line), 32'd0);
   endtask

   // Runs from inside a frame accepted at cycle e through its done pulse.
   task automatic finish_frame(input int unsigned e, input int d0, input int f0);
      tick(int'(e + FRAME - 1) - int'(cyc));
      check("busy_last_cycle", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      tick(1);
      check("busy_end", 32'(busy), 32'd0);
      check("done_pulse", 32'(done), 32'd1);
      check("line_after_stop", 32'(line), 32'd1);
      tick(1);
      check("done_one_cycle", 32'(done), 32'd0);
      tick(3);
      check("done_count", 32'(done_count - d0), 32'd1);
      check("frame_count", 32'(frames - f0), 32'd1);
      check("done_latency", last_done_cyc - e, 32'(FRAME));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int unsigned e1;
      int unsigned e2;
      int          d0;
      int          f0;
      int          bad;

      reset  = 1'b1;
      strobe = 1'b0;
      data   = 8'h00;

      // Reset and idle hold
      tick(10);
      check("reset_line", 32'(line), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      reset = 1'b0;
      bad   = 0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      check("idle_hold_bad_cycles", 32'(bad), 32'd0);
      check("idle_no_frames", 32'(frames), 32'd0);
      $display("idle: %0d cycles held, %0d deviations", 200, bad);

      // Single byte 0xA5
      d0 = done_count; f0 = frames;
      send(8'hA5, e1);
      finish_frame(e1, d0, f0);

      // Byte capture: data changes right after acceptance
      d0 = done_count; f0 = frames;
      send(8'h3C, e1);
      data = 8'hFF;
      finish_frame(e1, d0, f0);
      data = 8'h00;

      // Strobe while busy is ignored
      d0 = done_count; f0 = frames;
      send(8'h00, e1);
      tick(39);
      strobe = 1'b1;
      data   = 8'hFF;
      tick(1);
      strobe = 1'b0;
      data   = 8'h00;
      check("busy_strobe_ignored", 32'(busy), 32'd1);
      finish_frame(e1, d0, f0);
      tick(20);
      check("no_queued_frame", 32'(busy), 32'd0);
      check("no_queued_frame_count", 32'(frames - f0), 32'd1);

      // Back-to-back: strobe held through the done cycle
      d0 = done_count; f0 = frames;
      send(8'h55, e1);
      tick(int'(e1 + FRAME - 1) - int'(cyc));
      strobe = 1'b1;
      data   = 8'hAA;
      tick(1);
      check("b2b_first_done", 32'(done), 32'd1);
      check("b2b_idle_in_done", 32'(busy), 32'd0);
      tick(1);
      strobe = 1'b0;
      e2     = cyc;
      exp_q.push_back(8'hAA);
      check("b2b_accept_busy", 32'(busy), 32'd1);
      check("b2b_accept_line", 32'(line), 32'd0);
      tick(3);
      check("b2b_start_offset", last_start_cyc - e1, 32'(FRAME + 1));
      check("b2b_first_done_count", 32'(done_count - d0), 32'd1);
      data = 8'h00;
      finish_frame(e2, d0 + 1, f0 + 1);
      // acceptance lands on the edge after done, so done-to-done is one frame plus one
      check("b2b_done_spacing", last_done_cyc - prev_done_cyc, 32'(FRAME + 1));

      // Reset in the middle of a frame
      d0 = done_count; f0 = frames;
      send(8'h81, e1);
      tick(34);
      reset = 1'b1;
      tick(1);
      check("midreset_line", 32'(line), 32'd1);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_done", 32'(done), 32'd0);
      reset = 1'b0;
      exp_q.delete();
      tick(150);
      check("midreset_no_done", 32'(done_count - d0), 32'd0);
      check("midreset_no_frame", 32'(frames - f0), 32'd0);
      check("midreset_idle", 32'(busy), 32'd0);
      d0 = done_count; f0 = frames;
      send(8'h81, e1);
      finish_frame(e1, d0, f0);

      // Reset and strobe on the same edge: reset wins
      f0     = frames;
      reset  = 1'b1;
      strobe = 1'b1;
      data   = 8'h5A;
      tick(1);
      check("reset_vs_strobe_busy", 32'(busy), 32'd0);
      check("reset_vs_strobe_line", 32'(line), 32'd1);
      reset  = 1'b0;
      strobe = 1'b0;
      tick(20);
      check("reset_vs_strobe_idle", 32'(busy), 32'd0);
      check("reset_vs_strobe_frames", 32'(frames - f0), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
